mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data: grant next cycle, ready one cycle after ack.
// Requesters are held off by stall_if/stall_mem; data wins up to MAX_D_RUN times while fetch waits.
module mem_port_arbiter #(
  parameter int TIMEOUT   = 15,
  parameter int MAX_D_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
  localparam logic [3:0] RUN_LIM     = 4'(MAX_D_RUN);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t     state;
  logic [7:0] to_cnt;
  logic [3:0] run_cnt;
  logic       grant_d;
  logic       grant_if;

  // Data keeps priority until it has won RUN_LIM grants in a row over a waiting fetch.
  always_comb begin
    grant_d  = d_req && ((run_cnt < RUN_LIM) || !if_req);
    grant_if = if_req && !grant_d;
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      to_cnt    <= 8'd0;
      run_cnt   <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= 8'd0;
          if (grant_d) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            run_cnt   <= if_req ? run_cnt + 4'd1 : 4'd0;
          end else if (grant_if) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'd0;
            run_cnt   <= 4'd0;
          end else if (!if_req) begin
            run_cnt <= 4'd0;
          end
        end
        IF_BUSY, D_BUSY: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (mem_ack || (to_cnt == TIMEOUT_LIM)) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == IF_BUSY) begin
              if_ready <= 1'b1;
            end else begin
              d_ready <= 1'b1;
            end
            if (mem_ack) begin
              if (state == IF_BUSY) begin
                if_rdata <= mem_rdata;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              err <= 1'b1;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              if (state == IF_BUSY) begin
                if_rdata <= 32'd0;
              end else begin
                d_rdata <= 32'd0;
              end
            end
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, randomized run vs a model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT   = 15;
  localparam int MAX_D_RUN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_D_RUN(MAX_D_RUN)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: acks after a per-access delay counted from mem_req rising.
  bit          rsp_random = 1'b0;
  int          dir_delay = 0;
  logic [31:0] dir_rdata = 32'd0;
  int          rsp_n = 0;
  int          req_age = 0;
  int          cur_delay = 0;
  bit          prev_req = 1'b0;
  int          delays[64];

  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (!prev_req) begin
        req_age   = 0;
        cur_delay = rsp_random ? delays[rsp_n % 64] : dir_delay;
        rsp_n++;
      end else begin
        req_age++;
      end
      mem_ack   = (req_age == cur_delay);
      mem_rdata = mem_ack ? (rsp_random ? rd_of(mem_addr) : dir_rdata) : $urandom;
      prev_req  = 1'b1;
    end else begin
      mem_ack   = rsp_random ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      prev_req  = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, ".mem_req"},   32'(mem_req),   32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".if_rdata"},  if_rdata,       32'd0);
    chk({tag, ".d_rdata"},   d_rdata,        32'd0);
    chk({tag, ".if_ready"},  32'(if_ready),  32'd0);
    chk({tag, ".d_ready"},   32'(d_ready),   32'd0);
    chk({tag, ".err"},       32'(err),       32'd0);
    chk({tag, ".err_count"}, 32'(err_count), 32'd0);
    chk({tag, ".stall_if"},  32'(stall_if),  32'd0);
    chk({tag, ".stall_mem"}, 32'(stall_mem), 32'd0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rd;
    int          delay;     // ack in mem_req cycle delay+1
    int          exp_lat;   // sample index of ready, request sampled at index 1
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_ec;
  } vec_t;

  task automatic do_tx(input vec_t v, input int k);
    int          lat;
    bit          got;
    bit          first;
    bit          other;
    logic        e;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    string       t;
    t = $sformatf("vec%0d", k);
    dir_delay = v.delay;
    dir_rdata = v.mem_rd;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    lat = 0; got = 1'b0; first = 1'b1; other = 1'b0; e = 1'b0; we = 1'b0; a = '0; wd = '0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_req && first) begin
        first = 1'b0; a = mem_addr; we = mem_we; wd = mem_wdata;
      end
      if (v.is_d ? if_ready : d_ready) other = 1'b1;
      if (v.is_d ? d_ready : if_ready) begin
        got = 1'b1; e = err;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk({t, ".ready_seen"}, 32'(got), 32'd1);
    chk({t, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({t, ".err"}, 32'(e), 32'(v.exp_err));
    chk({t, ".rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    chk({t, ".mem_addr"}, a, v.addr);
    chk({t, ".mem_we"}, 32'(we), 32'(v.we));
    if (v.is_d) chk({t, ".mem_wdata"}, wd, v.wdata);
    chk({t, ".err_count"}, 32'(err_count), 32'(v.exp_ec));
    chk({t, ".other_ready"}, 32'(other), 32'd0);
  endtask

  // Transaction-level reference: each grant occupies the port for a known number of
  // cycles derived from the chosen ack delay, then one ready cycle, then re-arbitration.
  int          m_left, m_side, m_run, m_n;
  bit          m_abort;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
  logic        e_we, e_if_ready, e_d_ready, e_err;
  logic [7:0]  e_ec;

  task automatic model_reset();
    m_left = 0; m_side = 0; m_run = 0; m_n = rsp_n; m_abort = 1'b0;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
    e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0; e_ec = 8'd0;
  endtask

  task automatic model_step();
    int d;
    e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_abort) begin
          e_err = 1'b1;
          if (e_ec != 8'hFF) e_ec = e_ec + 8'd1;
          if (m_side == 1) e_if_rdata = '0; else e_d_rdata = '0;
        end else if (m_side == 1) begin
          e_if_rdata = rd_of(e_addr);
        end else if (!e_we) begin
          e_d_rdata = rd_of(e_addr);
        end
        if (m_side == 1) e_if_ready = 1'b1; else e_d_ready = 1'b1;
        m_side = 0;
      end
    end else begin
      m_side = 0;
      if (d_req && (m_run < MAX_D_RUN || !if_req)) begin
        m_side = 2; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
        m_run = if_req ? m_run + 1 : 0;
      end else if (if_req) begin
        m_side = 1; e_addr = if_addr; e_we = 1'b0;
        m_run = 0;
      end else begin
        m_run = 0;
      end
      if (m_side != 0) begin
        d = delays[m_n % 64];
        m_n++;
        m_abort = (d > TIMEOUT);
        m_left  = m_abort ? TIMEOUT + 1 : d + 1;
      end
    end
  endtask

  task automatic model_check();
    chk("rnd.mem_req", 32'(mem_req), 32'(m_left > 0));
    if (m_left > 0) begin
      chk("rnd.mem_addr", mem_addr, e_addr);
      chk("rnd.mem_we", 32'(mem_we), 32'(e_we));
      if (m_side == 2) chk("rnd.mem_wdata", mem_wdata, e_wdata);
    end
    chk("rnd.if_ready", 32'(if_ready), 32'(e_if_ready));
    chk("rnd.d_ready", 32'(d_ready), 32'(e_d_ready));
    chk("rnd.err", 32'(err), 32'(e_err));
    chk("rnd.if_rdata", if_rdata, e_if_rdata);
    chk("rnd.d_rdata", d_rdata, e_d_rdata);
    chk("rnd.err_count", 32'(err_count), 32'(e_ec));
    chk("rnd.stall_if", 32'(stall_if), 32'(if_req & ~e_if_ready));
    chk("rnd.stall_mem", 32'(stall_mem), 32'(d_req & ~e_d_ready));
  endtask

  task automatic drive_agents();
    if (if_req) begin
      if (e_if_ready) begin
        if ($urandom_range(0, 1) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
        else if_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req) begin
      if (e_d_ready) begin
        if ($urandom_range(0, 1) == 1) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end else begin
          d_req = 1'b0;
        end
      end
    end else if ($urandom_range(0, 1) == 0) begin
      d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        32'h00500093, 0,   2,  1'b0, 32'h00500093, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,        32'h12345678, 2,   4,  1'b0, 32'h12345678, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 32'h40,   32'hDEADBEEF, 32'h0BADF00D, 1,   3,  1'b0, 32'h12345678, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h3000, 32'h0,        32'hCAFEF00D, 14,  16, 1'b0, 32'hCAFEF00D, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 32'h3004, 32'h0,        32'h11112222, 15,  17, 1'b0, 32'h11112222, 8'd0};
    vecs[5] = '{1'b1, 1'b0, 32'h3008, 32'h0,        32'h55555555, 200, 17, 1'b1, 32'h0,        8'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h104,  32'h0,        32'h66666666, 200, 17, 1'b1, 32'h0,        8'd2};
    vecs[7] = '{1'b0, 1'b0, 32'h108,  32'h0,        32'h00A00113, 3,   5,  1'b0, 32'h00A00113, 8'd2};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    for (int k = 0; k < 8; k++) do_tx(vecs[k], k);

    // Fetch and load requested on the same edge: data first, one idle cycle, then fetch.
    begin
      int g1 = -1, g2 = -1, dr = -1, ir = -1, stall_low = 0;
      logic [31:0] a1 = '0, a2 = '0;
      bit prev = 1'b0;
      dir_delay = 1; dir_rdata = 32'h7777_0000;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      for (int c = 1; c <= 40 && ir < 0; c++) begin
        @(negedge clk);
        if (mem_req && !prev) begin
          if (g1 < 0) begin g1 = c; a1 = mem_addr; end
          else if (g2 < 0) begin g2 = c; a2 = mem_addr; end
        end
        prev = mem_req;
        if (d_ready && dr < 0) dr = c;
        if (if_ready && ir < 0) ir = c;
        else if (!stall_if) stall_low++;
        if (d_ready) d_req = 1'b0;
        if (if_ready) if_req = 1'b0;
      end
      chk("sim.first_addr", a1, 32'h2000);
      chk("sim.second_addr", a2, 32'h200);
      chk("sim.first_grant", 32'(g1), 32'd1);
      chk("sim.d_ready_at", 32'(dr), 32'd3);
      chk("sim.second_grant", 32'(g2), 32'd4);
      chk("sim.if_ready_at", 32'(ir), 32'd6);
      chk("sim.stall_if_low", 32'(stall_low), 32'd0);
      chk("sim.if_rdata", if_rdata, 32'h7777_0000);
    end

    // Data held continuously against a waiting fetch.
    begin
      int nd = 0;
      bit seen_if = 1'b0, done = 1'b0, prev = 1'b0;
      dir_delay = 0; dir_rdata = 32'h0101_0101;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; if_req = 1'b1; if_addr = 32'h600;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (mem_req && !prev) begin
          if (mem_addr == 32'h600) seen_if = 1'b1;
          else if (!seen_if) nd++;
        end
        prev = mem_req;
        if (if_ready) done = 1'b1;
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("starve.if_done", 32'(done), 32'd1);
      chk("starve.if_granted", 32'(seen_if), 32'd1);
      chk("starve.d_grants", 32'(nd), 32'(MAX_D_RUN));
    end

    // Request dropped while the access is in flight.
    begin
      bit got = 1'b0;
      dir_delay = 3; dir_rdata = 32'h3C3C_3C3C;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      @(negedge clk);
      chk("drop.mem_req", 32'(mem_req), 32'd1);
      chk("drop.stall_mem", 32'(stall_mem), 32'd1);
      d_req = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (d_ready) got = 1'b1;
      end
      chk("drop.d_ready", 32'(got), 32'd1);
      chk("drop.d_rdata", d_rdata, 32'h3C3C_3C3C);
    end

    // Reset in the third busy cycle of a data access.
    begin
      int busy = 0, stray = 0;
      dir_delay = 200;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
      for (int c = 0; c < 10 && busy < 3; c++) begin
        @(negedge clk);
        if (mem_req) busy++;
      end
      chk("rstmid.busy_cycles", 32'(busy), 32'd3);
      reset = 1'b1; d_req = 1'b0;
      @(negedge clk);
      check_reset_vals("rstmid");
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (d_ready || err || mem_req) stray++;
      end
      chk("rstmid.stray", 32'(stray), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 9);
      delays[i] = (r < 6) ? r : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? 16 : 200;
    end
    rsp_random = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      model_check();
      drive_agents();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
